product_display_ctrl: RTL and testbench

//  Shows the multiplier product on a multiplexed active-low 7-segment display.

---
 rtl/product_display_ctrl_pkg.sv | 42 ++++
 rtl/product_display_ctrl_bin2bcd_seq.sv | 79 +++++++
 rtl/product_display_ctrl.sv | 126 ++++++++++++
 tb/tb_product_display_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/product_display_ctrl_pkg.sv
// Shared constants, state type and helpers for the product display controller.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package product_display_ctrl_pkg;

    typedef enum logic {S_IDLE, S_CONV} conv_state_e;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_OFF;
        endcase
        return code;
    endfunction

    // Decimal digits needed for a pw-bit value: ceil(pw * log10(2)).
    function automatic int digits_needed(input int pw);
        return (pw * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/product_display_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock, PW steps.
// done is high in the final step; bcd then carries the completed result.
module bin2bcd_seq
    import product_display_ctrl_pkg::*;
#(
    parameter int PW     = 8,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [PW-1:0]         bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (PW > 1) ? $clog2(PW) : 1;

    logic          running_q, running_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic [PW-1:0] shift_q, shift_d;

    logic [BW-1:0]    adj;
    logic [BW+PW-1:0] cat;
    logic [BW-1:0]    bcd_step;
    logic [PW-1:0]    shift_step;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        cat        = {adj, shift_q} << 1;
        bcd_step   = cat[BW+PW-1:PW];
        shift_step = cat[PW-1:0];
    end

    always_comb begin
        running_d = running_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        shift_d   = shift_q;
        if (start) begin
            running_d = 1'b1;
            cnt_d     = '0;
            bcd_d     = '0;
            shift_d   = bin;
        end else if (running_q) begin
            bcd_d   = bcd_step;
            shift_d = shift_step;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(PW - 1)) begin
                running_d = 1'b0;
            end
        end
    end

    assign done = running_q && (cnt_q == CW'(PW - 1));
    assign bcd  = bcd_step;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            shift_q   <= '0;
        end else begin
            running_q <= running_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            shift_q   <= shift_d;
        end
    end

endmodule

// File: rtl/product_display_ctrl.sv
// Accepts a binary product over valid/ready, converts it to BCD and scans it
// onto a multiplexed active-low 7-segment display with anti-ghost blanking.
module product_display_ctrl
    import product_display_ctrl_pkg::*;
#(
    parameter int PW           = 8,
    parameter int DIGITS       = 4,
    parameter int BLANK_CYCLES = 4,
    parameter int LZB          = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              tick_1k,
    input  logic              prod_valid,
    input  logic [PW-1:0]     prod,
    output logic              prod_ready,
    output logic              busy,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg
);

    localparam logic [DIGITS-1:0] AN_OFF = '1;
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BCW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    if (DIGITS < digits_needed(PW)) begin : g_bad_digits
        $error("DIGITS too small to display a PW-bit product");
    end

    conv_state_e           state_q, state_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BCW-1:0]        blank_q, blank_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;

    logic                  start;
    logic                  conv_done;
    logic [4*DIGITS-1:0]   conv_bcd;
    logic [3:0]            digit;
    logic                  lead_blank;

    assign prod_ready = (state_q == S_IDLE);
    assign busy       = (state_q == S_CONV);
    assign start      = prod_valid && prod_ready;

    bin2bcd_seq #(
        .PW     (PW),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .bin   (prod),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_CONV;
            S_CONV: begin
                if (conv_done) begin
                    disp_d  = conv_bcd;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A tick always wins over the countdown so back-to-back ticks keep blanking.
    always_comb begin
        idx_d   = idx_q;
        blank_d = blank_q;
        if (tick_1k) begin
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
            blank_d = BCW'(BLANK_CYCLES);
        end else if (blank_q != '0) begin
            blank_d = blank_q - BCW'(1);
        end
    end

    always_comb begin
        digit      = disp_q[4*idx_q +: 4];
        lead_blank = 1'b0;
        if (LZB != 0 && idx_q != '0) begin
            lead_blank = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                if (i >= int'(idx_q) && disp_q[4*i +: 4] != 4'd0) begin
                    lead_blank = 1'b0;
                end
            end
        end
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (blank_q == '0) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = lead_blank ? SEG_OFF : seg_encode(digit);
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            disp_q  <= '0;
            idx_q   <= '0;
            blank_q <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            idx_q   <= idx_d;
            blank_q <= blank_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

endmodule

// File: tb/tb_product_display_ctrl.sv
// Directed bench for product_display_ctrl: default build, an LZB=0 build and a
// BLANK_CYCLES=0 build share stimulus and are checked side by side.
module tb_product_display_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       tick_1k;
    logic       prod_valid;
    logic [7:0] prod;

    logic       ready_m, busy_m, ready_f, busy_f, ready_z, busy_z;
    logic [3:0] an_m, an_f, an_z;
    logic [6:0] seg_m, seg_f, seg_z;

    int checks   = 0;
    int failures = 0;
    int scan_idx = 0;

    always #5 clk = ~clk;

    product_display_ctrl #(.PW(8), .DIGITS(4), .BLANK_CYCLES(4), .LZB(1)) dut_main (
        .clk(clk), .rstn(rstn), .tick_1k(tick_1k), .prod_valid(prod_valid), .prod(prod),
        .prod_ready(ready_m), .busy(busy_m), .an(an_m), .seg(seg_m)
    );

    product_display_ctrl #(.PW(8), .DIGITS(4), .BLANK_CYCLES(4), .LZB(0)) dut_full (
        .clk(clk), .rstn(rstn), .tick_1k(tick_1k), .prod_valid(prod_valid), .prod(prod),
        .prod_ready(ready_f), .busy(busy_f), .an(an_f), .seg(seg_f)
    );

    product_display_ctrl #(.PW(8), .DIGITS(4), .BLANK_CYCLES(0), .LZB(1)) dut_noblank (
        .clk(clk), .rstn(rstn), .tick_1k(tick_1k), .prod_valid(prod_valid), .prod(prod),
        .prod_ready(ready_z), .busy(busy_z), .an(an_z), .seg(seg_z)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] onecold(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_once;
        tick_1k = 1'b1;
        @(negedge clk);
        tick_1k = 1'b0;
    endtask

    // Accept a product and wait until the committed value is on the scan outputs.
    task automatic apply_stimulus(input logic [7:0] v);
        prod       = v;
        prod_valid = 1'b1;
        @(negedge clk);
        prod_valid = 1'b0;
        wait_cycles(9);
    endtask

    // Step through all four digits; expectations packed {d3,d2,d1,d0}, 7 bits each.
    task automatic scan_all(input logic [27:0] exp_lzb, input logic [27:0] exp_full);
        for (int k = 0; k < 4; k++) begin
            int d;
            d = (scan_idx + 1) % 4;
            tick_once;
            scan_idx = d;
            wait_cycles(1);
            check_output($sformatf("blank_gap_an_d%0d", d), an_m, 4'hF);
            check_output($sformatf("noblank_an_d%0d", d), an_z, onecold(d));
            wait_cycles(4);
            check_output($sformatf("scan_an_d%0d", d), an_m, onecold(d));
            check_output($sformatf("scan_seg_d%0d", d), seg_m, exp_lzb[7*d +: 7]);
            check_output($sformatf("nolzb_seg_d%0d", d), seg_f, exp_full[7*d +: 7]);
            wait_cycles(4);
        end
    endtask

    initial begin
        rstn       = 1'b0;
        tick_1k    = 1'b0;
        prod_valid = 1'b0;
        prod       = 8'd0;

        // Reset values
        wait_cycles(2);
        check_output("rst_an", an_m, 4'hF);
        check_output("rst_seg", seg_m, 7'h7F);
        check_output("rst_ready", ready_m, 1'b1);
        check_output("rst_busy", busy_m, 1'b0);
        rstn = 1'b1;
        wait_cycles(1);
        check_output("first_an", an_m, 4'hE);
        check_output("first_seg", seg_m, 7'h40);
        check_output("first_seg_nolzb", seg_f, 7'h40);

        // Idle scan of value 0
        scan_all({7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40});

        // 225: exact ready-low window and commit latency
        prod       = 8'd225;
        prod_valid = 1'b1;
        @(negedge clk);
        prod_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_output($sformatf("conv_ready_low_%0d", k), ready_m, 1'b0);
            check_output($sformatf("conv_busy_%0d", k), busy_m, 1'b1);
            check_output($sformatf("conv_seg_stable_%0d", k), seg_m, 7'h40);
            @(negedge clk);
        end
        check_output("conv_ready_back", ready_m, 1'b1);
        check_output("conv_busy_done", busy_m, 1'b0);
        check_output("seg_before_load", seg_m, 7'h40);
        wait_cycles(1);
        check_output("seg_after_commit", seg_m, 7'h12);
        scan_all({7'h7F, 7'h24, 7'h24, 7'h12}, {7'h40, 7'h24, 7'h24, 7'h12});

        // prod_valid held high; prod changed mid-conversion
        prod       = 8'd7;
        prod_valid = 1'b1;
        @(negedge clk);
        check_output("hold_ready_low", ready_m, 1'b0);
        prod = 8'd200;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            check_output($sformatf("hold_ready_low_%0d", k), ready_m, 1'b0);
        end
        @(negedge clk);
        check_output("hold_ready_return", ready_m, 1'b1);
        @(negedge clk);
        check_output("hold_reaccept", ready_m, 1'b0);
        check_output("hold_result_7", seg_m, 7'h78);
        prod_valid = 1'b0;
        wait_cycles(7);
        check_output("second_conv_ready_low", ready_m, 1'b0);
        wait_cycles(1);
        check_output("second_conv_ready_back", ready_m, 1'b1);
        wait_cycles(2);
        check_output("no_extra_accept_ready", ready_m, 1'b1);
        check_output("no_extra_accept_busy", busy_m, 1'b0);
        scan_all({7'h7F, 7'h24, 7'h40, 7'h40}, {7'h40, 7'h24, 7'h40, 7'h40});

        // Embedded zeros
        apply_stimulus(8'd100);
        scan_all({7'h7F, 7'h79, 7'h40, 7'h40}, {7'h40, 7'h79, 7'h40, 7'h40});

        // Async reset in the middle of a conversion
        prod       = 8'd99;
        prod_valid = 1'b1;
        @(negedge clk);
        prod_valid = 1'b0;
        wait_cycles(3);
        check_output("pre_reset_an", an_m, 4'hE);
        #2;
        rstn = 1'b0;
        #1;
        check_output("async_rst_an", an_m, 4'hF);
        check_output("async_rst_seg", seg_m, 7'h7F);
        check_output("async_rst_ready", ready_m, 1'b1);
        check_output("async_rst_busy", busy_m, 1'b0);
        check_output("async_rst_an_noblank", an_z, 4'hF);
        @(negedge clk);
        rstn     = 1'b1;
        scan_idx = 0;
        wait_cycles(12);
        check_output("no_commit_seg", seg_m, 7'h40);
        check_output("no_commit_ready", ready_m, 1'b1);
        check_output("no_commit_busy", busy_m, 1'b0);
        scan_all({7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40});

        // tick_1k every clock
        begin
            int s;
            s = scan_idx;
            tick_1k = 1'b1;
            for (int k = 1; k <= 13; k++) begin
                @(negedge clk);
                if (k >= 2) begin
                    check_output($sformatf("fast_tick_an_%0d", k), an_m, 4'hF);
                end
                check_output($sformatf("fast_tick_noblank_%0d", k), an_z, onecold((s + k - 1) % 4));
            end
            tick_1k  = 1'b0;
            scan_idx = (s + 13) % 4;
            wait_cycles(5);
            check_output("fast_tick_wrap_an", an_m, onecold(scan_idx));
            check_output("fast_tick_wrap_noblank", an_z, onecold(scan_idx));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
